// File: rtl/obuf_pkg.sv
// Shared types and constants for the ping-pong output line buffer.
// Optional feature macro used by the top: OBUF_LINE_CNT_EN.
package obuf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int RAM_RD_LAT = 1;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } skid_word_t;

  function automatic logic bank_writable(input bank_state_e s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/obuf_rd_skid.sv
// Two-entry output FIFO that absorbs the RAM read latency and grants read credit
// so the drain side sustains one pixel per clock with AXI-style hold.
module obuf_rd_skid
  import obuf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       rd_issue,
  input  logic       rd_issue_last,
  input  logic [7:0] rd_data,
  output logic       can_issue,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int OCC_W = $clog2(SKID_DEPTH + RAM_RD_LAT + 1);

  skid_word_t       mem [SKID_DEPTH];
  skid_word_t       head;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             inflight_q, inflight_last_q;
  logic             push, pop;
  logic [OCC_W-1:0] occ_after;

  assign push      = inflight_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem[rptr_q];
  assign out_data  = out_valid ? head.data : 8'h00;
  assign out_last  = out_valid && head.last;

  // Entries held plus the read in flight, after this cycle's pop, must leave room.
  assign occ_after = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign can_issue = occ_after < OCC_W'(SKID_DEPTH);

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= '{last: inflight_last_q, data: rd_data};
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else if (flush) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue_last;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_s_d_2048x8.sv
// Simple dual-port line RAM: one write port, one registered read port, same clock.
module ram_s_d_2048x8 #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: RAM arrays get no reset; a reset would stop them mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/output_ram_line_buffer.sv
// Ping-pong output line buffer: packs compute pixels into two line banks and drains
// completed lines to the DDR writer. Optional OBUF_LINE_CNT_EN adds o_line_cnt.
module output_ram_line_buffer
  import obuf_pkg::*;
#(
  parameter int IMAGE_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_frame_start,
  input  logic [IMAGE_WIDTH-1:0] i_line_width,
  input  logic                   i_pix_valid,
  input  logic [7:0]             i_pix_data,
  output logic                   o_pix_ready,
  output logic                   o_ddr_valid,
  output logic [7:0]             o_ddr_data,
  output logic                   o_ddr_last,
  input  logic                   i_ddr_ready,
`ifdef OBUF_LINE_CNT_EN
  output logic [15:0]            o_line_cnt,
`endif
  output logic                   o_line_done
);

  bank_state_e            bank_q [2];
  bank_state_e            bank_d [2];
  bank_state_e            wr_state, rd_state;
  logic                   wr_bank_q, rd_bank_q, rd_sel_q;
  logic [IMAGE_WIDTH-1:0] wr_addr_q, rd_addr_q, width_m1_q;
  logic                   rd_all_q, active_q, line_done_q;
  logic                   wr_acc, wr_end, rd_pending, rd_issue, rd_end;
  logic                   can_issue, drain_done;
  logic [7:0]             bank_rdata [2];

  assign wr_state = bank_q[wr_bank_q];
  assign rd_state = bank_q[rd_bank_q];

  // active_q keeps ready low in the first cycle after reset so every output starts at 0.
  assign o_pix_ready = active_q && bank_writable(wr_state) && !i_frame_start;
  assign wr_acc      = i_pix_valid && o_pix_ready;
  assign wr_end      = (wr_addr_q == width_m1_q);

  assign rd_pending  = (rd_state == BANK_FULL) || ((rd_state == BANK_DRAINING) && !rd_all_q);
  assign rd_issue    = rd_pending && can_issue && !i_frame_start;
  assign rd_end      = (rd_addr_q == width_m1_q);
  assign drain_done  = o_ddr_valid && i_ddr_ready && o_ddr_last;
  assign o_line_done = line_done_q;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      if (wr_acc && (wr_bank_q == 1'(b)))
        bank_d[b] = wr_end ? BANK_FULL : BANK_FILLING;
      if (rd_issue && (rd_bank_q == 1'(b)) && (bank_q[b] == BANK_FULL))
        bank_d[b] = BANK_DRAINING;
      if (drain_done && (rd_bank_q == 1'(b)))
        bank_d[b] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      width_m1_q  <= '0;
      rd_all_q    <= 1'b0;
      active_q    <= 1'b0;
      line_done_q <= 1'b0;
    end else if (i_frame_start) begin
      // Flush discards whatever is in the banks; a zero width behaves as width 1.
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      width_m1_q  <= (i_line_width == '0) ? '0 : i_line_width - IMAGE_WIDTH'(1);
      rd_all_q    <= 1'b0;
      active_q    <= 1'b1;
      line_done_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      active_q    <= 1'b1;
      line_done_q <= drain_done;
      if (wr_acc) begin
        wr_addr_q <= wr_end ? '0 : wr_addr_q + 1'b1;
        if (wr_end) wr_bank_q <= ~wr_bank_q;
      end
      if (rd_issue) begin
        rd_sel_q  <= rd_bank_q;
        rd_addr_q <= rd_end ? '0 : rd_addr_q + 1'b1;
        if (rd_end) rd_all_q <= 1'b1;
      end
      if (drain_done) begin
        rd_all_q  <= 1'b0;
        rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ram_s_d_2048x8 #(
      .ADDR_W(IMAGE_WIDTH),
      .DATA_W(8)
    ) u_ram (
      .clk  (clk),
      .we   (wr_acc && (wr_bank_q == 1'(b))),
      .waddr(wr_addr_q),
      .wdata(i_pix_data),
      .re   (rd_issue && (rd_bank_q == 1'(b))),
      .raddr(rd_addr_q),
      .rdata(bank_rdata[b])
    );
  end

  obuf_rd_skid u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (i_frame_start),
    .rd_issue     (rd_issue),
    .rd_issue_last(rd_end),
    .rd_data      (bank_rdata[rd_sel_q]),
    .can_issue    (can_issue),
    .out_valid    (o_ddr_valid),
    .out_data     (o_ddr_data),
    .out_last     (o_ddr_last),
    .out_ready    (i_ddr_ready)
  );

`ifdef OBUF_LINE_CNT_EN
  logic [15:0] line_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      line_cnt_q <= '0;
    else if (i_frame_start)
      line_cnt_q <= '0;
    else if (line_done_q && (line_cnt_q != 16'hFFFF))
      line_cnt_q <= line_cnt_q + 16'd1;
  end

  assign o_line_cnt = line_cnt_q;
`endif

endmodule

// File: tb/tb_output_ram_line_buffer.sv
// Directed self-checking bench for output_ram_line_buffer (default build and OBUF_LINE_CNT_EN).
module tb_output_ram_line_buffer;

  localparam int IW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_frame_start;
  logic [IW-1:0] i_line_width;
  logic          i_pix_valid;
  logic [7:0]    i_pix_data;
  logic          o_pix_ready;
  logic          o_ddr_valid;
  logic [7:0]    o_ddr_data;
  logic          o_ddr_last;
  logic          i_ddr_ready;
  logic          o_line_done;
`ifdef OBUF_LINE_CNT_EN
  logic [15:0]   o_line_cnt;
`endif

  output_ram_line_buffer #(.IMAGE_WIDTH(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_start(i_frame_start),
    .i_line_width (i_line_width),
    .i_pix_valid  (i_pix_valid),
    .i_pix_data   (i_pix_data),
    .o_pix_ready  (o_pix_ready),
    .o_ddr_valid  (o_ddr_valid),
    .o_ddr_data   (o_ddr_data),
    .o_ddr_last   (o_ddr_last),
    .i_ddr_ready  (i_ddr_ready),
`ifdef OBUF_LINE_CNT_EN
    .o_line_cnt   (o_line_cnt),
`endif
    .o_line_done  (o_line_done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] wq [$];
  logic [8:0] outq [$];
  int         wr_cnt, done_cnt, hold_err;
  logic       prev_stalled;
  logic [8:0] prev_word;

  task automatic clear_scoreboard();
    wq.delete();
    outq.delete();
    wr_cnt       = 0;
    done_cnt     = 0;
    hold_err     = 0;
    prev_stalled = 1'b0;
    prev_word    = '0;
  endtask

  // One clock: drive at posedge+1, sample at posedge+3, record what the next edge accepts.
  task automatic tick(input logic rdy);
    @(posedge clk);
    #1;
    i_ddr_ready = rdy;
    i_pix_valid = (wq.size() > 0);
    i_pix_data  = (wq.size() > 0) ? wq[0] : 8'h00;
    #2;
    if (o_line_done) done_cnt++;
    if (prev_stalled && (!o_ddr_valid || ({o_ddr_last, o_ddr_data} !== prev_word))) hold_err++;
    prev_stalled = o_ddr_valid && !rdy;
    prev_word    = {o_ddr_last, o_ddr_data};
    if (o_ddr_valid && rdy) outq.push_back({o_ddr_last, o_ddr_data});
    if (i_pix_valid && o_pix_ready) begin
      void'(wq.pop_front());
      wr_cnt++;
    end
  endtask

  task automatic frame(input logic [IW-1:0] w);
    @(posedge clk);
    #1;
    i_frame_start = 1'b1;
    i_line_width  = w;
    i_pix_valid   = 1'b0;
    i_ddr_ready   = 1'b0;
    @(posedge clk);
    #1;
    i_frame_start = 1'b0;
  endtask

  // mode 0: ready held high; mode 2: ready toggles 1,0,1,0...
  task automatic run_out(input int n, input int budget, input int mode);
    int k = 0;
    while (outq.size() < n && k < budget) begin
      tick((mode == 2) ? ((k % 2) == 0) : 1'b1);
      k++;
    end
    checks++;
    if (outq.size() < n) begin
      errors++;
      $display("FAIL run_out_timeout: got %0d outputs, expected %0d", outq.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_frame_start = 1'b0; i_line_width = '0;
    i_pix_valid = 1'b0; i_pix_data = '0; i_ddr_ready = 1'b0;
    #12;
    checks++; if (o_pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b, expected 0", o_pix_ready); end
    checks++; if (o_ddr_valid !== 1'b0) begin errors++; $display("FAIL reset_ddr_valid: got %b, expected 0", o_ddr_valid); end
    checks++; if (o_ddr_data !== 8'h00) begin errors++; $display("FAIL reset_ddr_data: got %h, expected 00", o_ddr_data); end
    checks++; if (o_ddr_last !== 1'b0) begin errors++; $display("FAIL reset_ddr_last: got %b, expected 0", o_ddr_last); end
    checks++; if (o_line_done !== 1'b0) begin errors++; $display("FAIL reset_line_done: got %b, expected 0", o_line_done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [8:0] exp;
    frame(11'd8);
    clear_scoreboard();
    for (int i = 0; i < 8; i++) wq.push_back(8'h10 + 8'(i));
    run_out(8, 60, 0);
    for (int i = 0; i < 5; i++) tick(1'b1);
    for (int i = 0; i < 8; i++) begin
      exp = {(i == 7), 8'h10 + 8'(i)};
      checks++;
      if (i >= outq.size() || outq[i] !== exp) begin
        errors++; $display("FAIL basic_pix[%0d]: got %h, expected %h", i, (i < outq.size()) ? outq[i] : 9'h1FF, exp);
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_line_done: got %0d pulses, expected 1", done_cnt); end
    checks++; if (outq.size() !== 8) begin errors++; $display("FAIL basic_count: got %0d outputs, expected 8", outq.size()); end
  endtask

  task automatic test_back_to_back();
    int d_cyc, w_cyc;
    logic [8:0] exp;
    frame(11'd4);
    clear_scoreboard();
    for (int i = 0; i < 12; i++) wq.push_back(8'(i));
    for (int i = 0; i < 20; i++) tick(1'b0);
    checks++; if (wr_cnt !== 8) begin errors++; $display("FAIL b2b_stall_writes: got %0d accepted, expected 8", wr_cnt); end
    checks++; if (o_pix_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b, expected 0", o_pix_ready); end
    d_cyc = -1; w_cyc = -1;
    for (int k = 0; k < 100 && outq.size() < 12; k++) begin
      tick(1'b1);
      if (done_cnt >= 1 && d_cyc < 0) d_cyc = k;
      if (wr_cnt >= 9 && w_cyc < 0) w_cyc = k;
    end
    checks++;
    if (d_cyc < 0 || w_cyc < d_cyc || (w_cyc - d_cyc) > 2) begin
      errors++; $display("FAIL b2b_resume: done at %0d, write at %0d, expected write within 2 cycles after done", d_cyc, w_cyc);
    end
    for (int i = 0; i < 12; i++) begin
      exp = {((i % 4) == 3), 8'(i)};
      checks++;
      if (i >= outq.size() || outq[i] !== exp) begin
        errors++; $display("FAIL b2b_pix[%0d]: got %h, expected %h", i, (i < outq.size()) ? outq[i] : 9'h1FF, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [8:0] exp;
    frame(11'd16);
    clear_scoreboard();
    for (int i = 0; i < 16; i++) wq.push_back(8'hC0 + 8'(i));
    run_out(16, 150, 2);
    for (int i = 0; i < 6; i++) tick(1'b1);
    for (int i = 0; i < 16; i++) begin
      exp = {(i == 15), 8'hC0 + 8'(i)};
      checks++;
      if (i >= outq.size() || outq[i] !== exp) begin
        errors++; $display("FAIL stall_pix[%0d]: got %h, expected %h", i, (i < outq.size()) ? outq[i] : 9'h1FF, exp);
      end
    end
    checks++; if (outq.size() !== 16) begin errors++; $display("FAIL stall_count: got %0d outputs, expected 16", outq.size()); end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable stalled cycles, expected 0", hold_err); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_line_done: got %0d pulses, expected 1", done_cnt); end
  endtask

  task automatic test_width1();
    frame(11'd1);
    clear_scoreboard();
    wq.push_back(8'hA5);
    wq.push_back(8'h5A);
    run_out(2, 40, 0);
    for (int i = 0; i < 5; i++) tick(1'b1);
    checks++; if (outq.size() < 1 || outq[0] !== 9'h1A5) begin errors++; $display("FAIL w1_pix0: got %h, expected 1a5", (outq.size() > 0) ? outq[0] : 9'h0); end
    checks++; if (outq.size() < 2 || outq[1] !== 9'h15A) begin errors++; $display("FAIL w1_pix1: got %h, expected 15a", (outq.size() > 1) ? outq[1] : 9'h0); end
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL w1_line_done: got %0d pulses, expected 2", done_cnt); end
  endtask

  task automatic test_frame_flush();
    logic [8:0] exp;
    frame(11'd8);
    clear_scoreboard();
    for (int i = 0; i < 13; i++) wq.push_back(8'h40 + 8'(i));
    for (int i = 0; i < 20; i++) tick(1'b0);
    checks++; if (wr_cnt !== 13) begin errors++; $display("FAIL flush_prefill: got %0d accepted, expected 13", wr_cnt); end
    run_out(2, 20, 0);
    frame(11'd8);
    #1;
    checks++; if (o_ddr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, expected 0", o_ddr_valid); end
    checks++; if (o_pix_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b, expected 1", o_pix_ready); end
    clear_scoreboard();
    for (int i = 0; i < 8; i++) wq.push_back(8'h20 + 8'(i));
    run_out(8, 60, 0);
    for (int i = 0; i < 6; i++) tick(1'b1);
    for (int i = 0; i < 8; i++) begin
      exp = {(i == 7), 8'h20 + 8'(i)};
      checks++;
      if (i >= outq.size() || outq[i] !== exp) begin
        errors++; $display("FAIL flush_pix[%0d]: got %h, expected %h", i, (i < outq.size()) ? outq[i] : 9'h1FF, exp);
      end
    end
    checks++; if (outq.size() !== 8) begin errors++; $display("FAIL flush_count: got %0d outputs, expected 8", outq.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL flush_line_done: got %0d pulses, expected 1", done_cnt); end
  endtask

`ifdef OBUF_LINE_CNT_EN
  task automatic test_line_cnt();
    frame(11'd2);
    clear_scoreboard();
    for (int i = 0; i < 6; i++) wq.push_back(8'h70 + 8'(i));
    run_out(6, 60, 0);
    for (int i = 0; i < 5; i++) tick(1'b1);
    checks++; if (o_line_cnt !== 16'd3) begin errors++; $display("FAIL line_cnt_three: got %0d, expected 3", o_line_cnt); end
    frame(11'd2);
    checks++; if (o_line_cnt !== 16'd0) begin errors++; $display("FAIL line_cnt_clear: got %0d, expected 0", o_line_cnt); end
  endtask
`endif

  task automatic test_async_reset();
    frame(11'd8);
    clear_scoreboard();
    for (int i = 0; i < 8; i++) wq.push_back(8'h90 + 8'(i));
    for (int i = 0; i < 12; i++) tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    checks++; if (o_ddr_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b, expected 1", o_ddr_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_ddr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b, expected 0", o_ddr_valid); end
    checks++; if (o_ddr_data !== 8'h00) begin errors++; $display("FAIL arst_data: got %h, expected 00", o_ddr_data); end
    checks++; if (o_ddr_last !== 1'b0) begin errors++; $display("FAIL arst_last: got %b, expected 0", o_ddr_last); end
    checks++; if (o_pix_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b, expected 0", o_pix_ready); end
    checks++; if (o_line_done !== 1'b0) begin errors++; $display("FAIL arst_line_done: got %b, expected 0", o_line_done); end
`ifdef OBUF_LINE_CNT_EN
    checks++; if (o_line_cnt !== 16'd0) begin errors++; $display("FAIL arst_line_cnt: got %0d, expected 0", o_line_cnt); end
`endif
    i_pix_valid = 1'b0;
    i_ddr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_scoreboard();
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_width1();
    test_frame_flush();
`ifdef OBUF_LINE_CNT_EN
    test_line_cnt();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
